// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order feature map.
// Horizontal pairs are reduced through a one-pixel hold register. Even-row pair
// maxima park in a half-row line buffer until the matching odd-row pair arrives.
module maxpool2x2_stream #(
  parameter int unsigned W      = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned IMG_W  = 14,
  parameter int unsigned IMG_H  = 14,
  parameter bit          SIGNED = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [CH*W-1:0] in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [CH*W-1:0] out_data_o,
  output logic            out_last_o
);

  localparam int unsigned HalfW = IMG_W / 2;
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned AW    = (HalfW > 1) ? $clog2(HalfW) : 1;

  localparam logic [CW-1:0] ColMax     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowMax     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColLastOut = CW'(2 * HalfW - 1);
  localparam logic [RW-1:0] RowLastOut = RW'(2 * (IMG_H / 2) - 1);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CH*W-1:0] hold_q, hold_d;
  logic            out_valid_q, out_valid_d;
  logic [CH*W-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  // Not reset: every entry is written on an even row before an odd row reads it.
  logic [CH*W-1:0] line_buf_q [HalfW];

  logic [AW-1:0]   lb_idx;
  logic [CH*W-1:0] hmax, pool;
  logic            accept, odd_col, odd_row, load, lb_we;

  function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic gt;
    if (SIGNED) gt = $signed(a) > $signed(b);
    else        gt = a > b;
    return gt ? a : b;
  endfunction

  // Input may only advance when the output register has room; clr blocks it.
  assign in_ready_o = (~out_valid_q | out_ready_i) & ~clr_i;
  assign accept     = in_valid_i & in_ready_o;
  assign odd_col    = col_q[0];
  assign odd_row    = row_q[0];
  assign load       = accept & odd_col & odd_row;
  assign lb_we      = accept & odd_col & ~odd_row;
  assign lb_idx     = AW'(col_q >> 1);

  // Per-lane horizontal pair max and full 2x2 window max.
  always_comb begin
    hmax = '0;
    pool = '0;
    for (int k = 0; k < CH; k++) begin
      hmax[k*W +: W] = lane_max(hold_q[k*W +: W], in_data_i[k*W +: W]);
      pool[k*W +: W] = lane_max(line_buf_q[lb_idx][k*W +: W], hmax[k*W +: W]);
    end
  end

  // Raster position counters and hold register next state.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      hold_d = '0;
    end else if (accept) begin
      if (!odd_col) hold_d = in_data_i;
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Output register: a new load beats a same-cycle drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (clr_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = pool;
      out_last_d  = (col_q == ColLastOut) && (row_q == RowLastOut);
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer: even-row pair maxima, indexed by output column.
  always_ff @(posedge clk_i) begin
    if (lb_we) line_buf_q[lb_idx] <= hmax;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: four instances (4x4, 5x4, signed 2x2 dual-lane,
// unsigned 2x2 dual-lane) share stimulus; one is selected per test.
module tb_maxpool2x2_stream;

  int cfg_w  [4] = '{4, 5, 2, 2};
  int cfg_h  [4] = '{4, 4, 2, 2};
  int cfg_ch [4] = '{1, 1, 2, 2};
  int cfg_sg [4] = '{0, 0, 1, 0};

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [15:0] in_data;
  int          sel;
  logic [3:0]  iv, ov, ol, ir;
  logic [7:0]  od0, od1;
  logic [15:0] od2, od3;

  always #5 clk = ~clk;

  assign iv[0] = in_valid && (sel == 0);
  assign iv[1] = in_valid && (sel == 1);
  assign iv[2] = in_valid && (sel == 2);
  assign iv[3] = in_valid && (sel == 3);

  maxpool2x2_stream #(.W(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .in_data_i(in_data[7:0]), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_data_o(od0), .out_last_o(ol[0]));
  maxpool2x2_stream #(.W(8), .CH(1), .IMG_W(5), .IMG_H(4), .SIGNED(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .in_data_i(in_data[7:0]), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_data_o(od1), .out_last_o(ol[1]));
  maxpool2x2_stream #(.W(8), .CH(2), .IMG_W(2), .IMG_H(2), .SIGNED(1'b1)) u_s (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .in_data_i(in_data), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_data_o(od2), .out_last_o(ol[2]));
  maxpool2x2_stream #(.W(8), .CH(2), .IMG_W(2), .IMG_H(2), .SIGNED(1'b0)) u_u (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(iv[3]), .in_ready_o(ir[3]),
    .in_data_i(in_data), .out_valid_o(ov[3]), .out_ready_i(out_ready),
    .out_data_o(od3), .out_last_o(ol[3]));

  typedef struct {
    int               sel;
    int               n_in;
    logic [19:0][15:0] px;
    int               n_out;
    logic [3:0][15:0] ex;
    logic [3:0]       lastm;
  } vec_t;

  vec_t        vt [7];
  logic [15:0] acc_q [$];
  logic [16:0] obs_q [$];
  int          errors, checks;
  bit          stall_mode, rel_pending, rand_ready;
  int          stall_cnt;

  function automatic logic [15:0] sel_data();
    case (sel)
      0:       return {8'h00, od0};
      1:       return {8'h00, od1};
      2:       return od2;
      default: return od3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample settled signals, record handshakes, advance past the edge.
  task automatic cycle();
    #1;
    if (in_valid && ir[sel]) acc_q.push_back(in_data);
    if (ov[sel] && out_ready) obs_q.push_back({ol[sel], sel_data()});
    if (stall_mode && ov[sel]) begin
      check("stall_data", sel_data(), 32'd5);
      check("stall_in_ready", ir[sel], 32'd0);
      stall_cnt++;
      if (stall_cnt == 5) begin
        stall_mode  = 1'b0;
        rel_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rel_pending) begin
      out_ready   = 1'b1;
      rel_pending = 1'b0;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [15:0] px, input bit gaps);
    int n0;
    int budget;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
    in_valid = 1'b1;
    in_data  = px;
    n0       = acc_q.size();
    budget   = 0;
    while (acc_q.size() == n0 && budget < 50) begin
      cycle();
      budget++;
    end
    if (acc_q.size() == n0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel %0h not accepted within %0d cycles", px, budget);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
    #1;
    check("rst_out_valid", ov[sel], 32'd0);
    check("rst_out_data", sel_data(), 32'd0);
    check("rst_out_last", ol[sel], 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    acc_q.delete();
    obs_q.delete();
    @(posedge clk);
    #1;
  endtask

  function automatic bit gt8(input logic [7:0] a, input logic [7:0] b, input int sg);
    if (sg != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Reference: pool every complete frame of accepted pixels directly from its 2D layout.
  task automatic model_check(input string tag);
    int          iw, ih, ch, fs, nf, idx;
    logic [16:0] exp_q [$];
    logic [15:0] pw;
    logic [7:0]  best, p;
    logic [15:0] v;
    iw = cfg_w[sel];
    ih = cfg_h[sel];
    ch = cfg_ch[sel];
    fs = iw * ih;
    nf = acc_q.size() / fs;
    check({tag, "_partial"}, acc_q.size() % fs, 32'd0);
    for (int f = 0; f < nf; f++)
      for (int oy = 0; oy < ih / 2; oy++)
        for (int ox = 0; ox < iw / 2; ox++) begin
          v = '0;
          for (int k = 0; k < ch; k++) begin
            best = 8'h00;
            for (int q = 0; q < 4; q++) begin
              idx = f * fs + (2 * oy + q / 2) * iw + 2 * ox + q % 2;
              pw  = acc_q[idx];
              p   = pw[k*8 +: 8];
              if (q == 0 || gt8(p, best, cfg_sg[sel])) best = p;
            end
            v[k*8 +: 8] = best;
          end
          exp_q.push_back({(oy == ih / 2 - 1) && (ox == iw / 2 - 1), v});
        end
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic check_frame_4x4(input string tag);
    logic [15:0] ex [4];
    int          nlast;
    ex    = '{16'd5, 16'd7, 16'd13, 16'd15};
    nlast = 0;
    check({tag, "_accepted"}, acc_q.size(), 32'd16);
    check({tag, "_count"}, obs_q.size(), 32'd4);
    for (int j = 0; j < 4 && j < obs_q.size(); j++) begin
      check($sformatf("%s_data%0d", tag, j), obs_q[j][15:0], ex[j]);
      if (obs_q[j][16]) nlast++;
    end
    if (obs_q.size() == 4) check({tag, "_last_pos"}, obs_q[3][16], 32'd1);
    check({tag, "_last_once"}, nlast, 32'd1);
  endtask

  initial begin
    errors = 0; checks = 0; sel = 0;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    stall_mode = 1'b0; rel_pending = 1'b0; rand_ready = 1'b0; stall_cnt = 0;

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      vt[i].px = '0;
      vt[i].ex = '0;
    end
    vt[0].sel = 0; vt[0].n_in = 16; vt[0].n_out = 4; vt[0].lastm = 4'b1000;
    for (int i = 0; i < 16; i++) vt[0].px[i] = 16'(i);
    vt[0].ex[0] = 16'd5; vt[0].ex[1] = 16'd7; vt[0].ex[2] = 16'd13; vt[0].ex[3] = 16'd15;
    vt[1].sel = 1; vt[1].n_in = 20; vt[1].n_out = 4; vt[1].lastm = 4'b1000;
    for (int i = 0; i < 20; i++) vt[1].px[i] = 16'(i);
    vt[1].ex[0] = 16'd6; vt[1].ex[1] = 16'd8; vt[1].ex[2] = 16'd16; vt[1].ex[3] = 16'd18;
    for (int i = 2; i < 7; i++) begin
      vt[i].n_in = 4; vt[i].n_out = 1; vt[i].lastm = 4'b0001;
    end
    vt[2].sel = 2; vt[3].sel = 3;
    vt[2].px[0] = 16'h0080; vt[2].px[1] = 16'h007F; vt[2].px[2] = 16'h00FF;
    vt[2].px[3] = 16'h0001;
    vt[3].px = vt[2].px;
    vt[2].ex[0] = 16'h007F; vt[3].ex[0] = 16'h00FF;
    vt[4].sel = 3; vt[5].sel = 2;
    vt[4].px[0] = 16'h2801; vt[4].px[1] = 16'h1E02; vt[4].px[2] = 16'h1403;
    vt[4].px[3] = 16'h0A04;
    vt[5].px = vt[4].px;
    vt[4].ex[0] = 16'h2804; vt[5].ex[0] = 16'h2804;
    vt[6].sel = 2;
    vt[6].px[0] = 16'h8080; vt[6].px[1] = 16'h7F7F; vt[6].px[2] = 16'hFFFF;
    vt[6].px[3] = 16'h0101;
    vt[6].ex[0] = 16'h7F7F;

    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      sel = vt[i].sel;
      do_reset();
      for (int j = 0; j < vt[i].n_in; j++) send(vt[i].px[j], 1'b0);
      drain();
      check($sformatf("v%0d_accepted", i), acc_q.size(), vt[i].n_in);
      check($sformatf("v%0d_count", i), obs_q.size(), vt[i].n_out);
      for (int j = 0; j < vt[i].n_out && j < obs_q.size(); j++) begin
        check($sformatf("v%0d_data%0d", i, j), obs_q[j][15:0], vt[i].ex[j]);
        check($sformatf("v%0d_last%0d", i, j), obs_q[j][16], vt[i].lastm[j]);
      end
    end

    // Backpressure: first output held for 5 cycles with input stalled.
    sel = 0;
    do_reset();
    out_ready  = 1'b0;
    stall_cnt  = 0;
    stall_mode = 1'b1;
    for (int j = 0; j < 16; j++) send(16'(j), 1'b0);
    drain();
    check("stall_cycles", stall_cnt, 32'd5);
    check_frame_4x4("stall");

    // Async reset after 6 pixels, then a clean frame.
    do_reset();
    for (int j = 0; j < 6; j++) send(16'(j), 1'b0);
    do_reset();
    for (int j = 0; j < 16; j++) send(16'(j), 1'b0);
    drain();
    check_frame_4x4("rst_mid");

    // Frame restart via clr after 6 pixels; pending output 5 is dropped.
    do_reset();
    for (int j = 0; j < 6; j++) send(16'(j), 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0063;
    #1;
    check("clr_in_ready", ir[sel], 32'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_out_valid", ov[sel], 32'd0);
    check("clr_out_last", ol[sel], 32'd0);
    acc_q.delete();
    obs_q.delete();
    for (int j = 0; j < 16; j++) send(16'(j), 1'b0);
    drain();
    check_frame_4x4("clr_mid");

    // Random frames with gaps and random backpressure on every configuration.
    for (int s = 0; s < 4; s++) begin
      sel = s;
      do_reset();
      rand_ready = 1'b1;
      for (int j = 0; j < 3 * cfg_w[s] * cfg_h[s]; j++) begin
        logic [15:0] px;
        px = 16'($urandom());
        if ($urandom_range(0, 3) == 0) px[7:0] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
        if ($urandom_range(0, 3) == 0) px[15:8] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        send(px, 1'b1);
      end
      drain();
      model_check($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
